irq_source_latch: RTL and testbench

- Three-source interrupt request stage that feeds the 3-input OR/priority decode in the interrupt path.
- Each raw request line is polarity-corrected, synchronised to sysclk, edge-detected and held in a pending flag.
- One registered combined request and encoded level are presented to the CPU side, with a four-phase acknowledge handshake that clears the serviced source.

---
 rtl/irq_source_latch.sv | 158 +++++++++++++++
 tb/tb_irq_source_latch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_latch.sv
// -----------------------------------------------------------------------------
// irq_source_latch
//
// Three-source interrupt request stage. Each raw request line is
// polarity-corrected, synchronised to sysclk, and edge-detected. A rising edge
// is held in a pending flag until the consumer acknowledges it. One
// registered combined request plus an encoded level are presented to the
// consumer, and a four-phase acknowledge handshake retires the granted source.
//
// Ports:
//   sysclk     in   1  system clock, rising-edge active
//   sys_rst_n  in   1  asynchronous active-low reset
//   req_in     in   3  raw request lines, asynchronous to sysclk
//   ack        in   1  acknowledge from the consumer, synchronous to sysclk
//   clr_all    in   1  synchronous clear of all pending flags and the FSM
//   pending    out  3  registered pending flags, one per source
//   irq_out    out  1  registered combined request
//   irq_level  out  2  granted source: 00 none, 01 src0, 10 src1, 11 src2
//   fsm_state  out  2  handshake FSM state (00 IDLE, 01 REQ, 10 WAIT_ACK_LOW)
//
// Handshake (four-phase):
//   irq_out rises with irq_level valid. Both hold until ack is seen high.
//   The edge that samples ack=1 drops irq_out/irq_level and clears the
//   granted pending bit. A new request is not presented until ack has been
//   seen low again and the FSM has spent one cycle in IDLE.
//
// SYNC_STAGES is intended to lie in 2..4.
// -----------------------------------------------------------------------------
module irq_source_latch #(
  parameter logic [2:0] INPUT_INVERT_MASK = 3'b000,
  parameter int         SYNC_STAGES       = 2
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic [2:0] req_in,
  input  logic       ack,
  input  logic       clr_all,
  output logic [2:0] pending,
  output logic       irq_out,
  output logic [1:0] irq_level,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ          = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] grant;

  // sync_q[0] is the first flop after polarity correction; the last stage
  // is the synchronised level used for edge detection.
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic [2:0] rise;
  logic [2:0] ack_clear;
  logic [2:0] pending_next;
  logic [1:0] top_idx;

  // Synchroniser chain and edge history.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in ^ INPUT_INVERT_MASK;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // The acknowledge only retires the granted bit, and only from REQ.
  assign ack_clear = (state == REQ && ack) ? (3'b001 << grant) : 3'b000;

  // clr_all dominates; a fresh edge beats a same-cycle acknowledge clear.
  always_comb begin
    pending_next = pending;
    if (clr_all) begin
      pending_next = 3'b000;
    end else begin
      pending_next = (pending & ~ack_clear) | rise;
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= 3'b000;
    end else begin
      pending <= pending_next;
    end
  end

  // Fixed priority: src2 > src1 > src0.
  always_comb begin
    top_idx = 2'd0;
    if (pending[2]) begin
      top_idx = 2'd2;
    end else if (pending[1]) begin
      top_idx = 2'd1;
    end else begin
      top_idx = 2'd0;
    end
  end

  // Handshake FSM with registered outputs. Grant is latched on entry to REQ
  // and held there, so a higher-priority arrival waits for the next IDLE.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      grant     <= 2'd0;
      irq_out   <= 1'b0;
      irq_level <= 2'b00;
    end else if (clr_all) begin
      state     <= IDLE;
      irq_out   <= 1'b0;
      irq_level <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pending != 3'b000) begin
            state     <= REQ;
            grant     <= top_idx;
            irq_out   <= 1'b1;
            irq_level <= top_idx + 2'd1;
          end
        end
        REQ: begin
          if (ack) begin
            state     <= WAIT_ACK_LOW;
            irq_out   <= 1'b0;
            irq_level <= 2'b00;
          end
        end
        WAIT_ACK_LOW: begin
          if (!ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          irq_out   <= 1'b0;
          irq_level <= 2'b00;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_irq_source_latch.sv
// -----------------------------------------------------------------------------
// tb_irq_source_latch
//
// Two instances: u_dut with default parameters, u_inv with source 1 treated
// as active-low. Observed word per instance is
// {pending[2:0], irq_out, irq_level[1:0], fsm_state[1:0]}.
// -----------------------------------------------------------------------------
module tb_irq_source_latch;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // clock / reset
  logic sysclk;
  logic sys_rst_n;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // DUT signals
  logic [2:0] req_in;
  logic       ack;
  logic       clr_all;
  logic [2:0] pending;
  logic       irq_out;
  logic [1:0] irq_level;
  logic [1:0] fsm_state;

  logic [2:0] req_inv;
  logic       ack_inv;
  logic       clr_inv;
  logic [2:0] pending_inv;
  logic       irq_out_inv;
  logic [1:0] irq_level_inv;
  logic [1:0] fsm_state_inv;

  irq_source_latch u_dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .req_in    (req_in),
    .ack       (ack),
    .clr_all   (clr_all),
    .pending   (pending),
    .irq_out   (irq_out),
    .irq_level (irq_level),
    .fsm_state (fsm_state)
  );

  irq_source_latch #(
    .INPUT_INVERT_MASK (3'b010),
    .SYNC_STAGES       (2)
  ) u_inv (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .req_in    (req_inv),
    .ack       (ack_inv),
    .clr_all   (clr_inv),
    .pending   (pending_inv),
    .irq_out   (irq_out_inv),
    .irq_level (irq_level_inv),
    .fsm_state (fsm_state_inv)
  );

  logic [7:0] obs_main;
  logic [7:0] obs_inv;
  assign obs_main = {pending, irq_out, irq_level, fsm_state};
  assign obs_inv  = {pending_inv, irq_out_inv, irq_level_inv, fsm_state_inv};

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] pack(input logic [2:0] p, input logic i,
                                      input logic [1:0] l, input logic [1:0] s);
    return {p, i, l, s};
  endfunction

  task automatic push_exp(input logic [7:0] e);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input logic [7:0] act);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, got %b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got pend=%b irq=%b lvl=%b st=%b, want pend=%b irq=%b lvl=%b st=%b",
                 name, act[7:5], act[4], act[3:2], act[1:0], e[7:5], e[4], e[3:2], e[1:0]);
      end
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge, outputs
  // are sampled 1 time unit after the following edge.
  task automatic step(input logic [2:0] r, input logic a, input logic c,
                      input logic [7:0] e, input string name);
    req_in  = r;
    ack     = a;
    clr_all = c;
    push_exp(e);
    @(posedge sysclk);
    #1;
    pop_cmp(name, obs_main);
  endtask

  task automatic step_inv(input logic [2:0] r, input logic a,
                          input logic [7:0] e, input string name);
    req_inv = r;
    ack_inv = a;
    push_exp(e);
    @(posedge sysclk);
    #1;
    pop_cmp(name, obs_inv);
  endtask

  // vector table
  typedef struct {
    logic [2:0] req;
    logic       ack;
    logic       clr;
    logic [2:0] pend;
    logic       irq;
    logic [1:0] lvl;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] r, input logic a, input logic c,
                              input logic [2:0] p, input logic i,
                              input logic [1:0] l, input logic [1:0] s);
    vec_t v;
    v.req = r; v.ack = a; v.clr = c;
    v.pend = p; v.irq = i; v.lvl = l; v.st = s;
    tbl.push_back(v);
  endfunction

  initial begin
    // single pulse on src0, full handshake, then ack in IDLE is ignored
    add(3'b001, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 1, 0, 3'b000, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 1, 0, 3'b000, 0, 2'b00, S_IDLE);
    // src0 and src2 together: src2 first, then src0; held level no retrigger
    add(3'b101, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b101, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b101, 0, 0, 3'b101, 0, 2'b00, S_IDLE);
    add(3'b101, 0, 0, 3'b101, 1, 2'b11, S_REQ);
    add(3'b101, 0, 0, 3'b101, 1, 2'b11, S_REQ);
    add(3'b101, 1, 0, 3'b001, 0, 2'b00, S_WAIT);
    add(3'b101, 1, 0, 3'b001, 0, 2'b00, S_WAIT);
    add(3'b101, 0, 0, 3'b001, 0, 2'b00, S_IDLE);
    add(3'b101, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 1, 0, 3'b000, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    // clr_all together with ack during REQ for src1
    add(3'b010, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b010, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b010, 1, 2'b10, S_REQ);
    add(3'b000, 1, 1, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    // clr_all in the cycle an edge is detected: the edge is lost
    add(3'b100, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 1, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    // new edge on granted src0 coinciding with ack: re-granted afterwards
    add(3'b001, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b001, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 1, 0, 3'b001, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b001, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 1, 0, 3'b000, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    // src2 arriving during REQ for src0 does not pre-empt
    add(3'b001, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b100, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 0, 0, 3'b001, 1, 2'b01, S_REQ);
    add(3'b000, 0, 0, 3'b101, 1, 2'b01, S_REQ);
    add(3'b000, 1, 0, 3'b100, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b100, 0, 2'b00, S_IDLE);
    add(3'b000, 0, 0, 3'b100, 1, 2'b11, S_REQ);
    add(3'b000, 1, 0, 3'b000, 0, 2'b00, S_WAIT);
    add(3'b000, 0, 0, 3'b000, 0, 2'b00, S_IDLE);

    // reset, inputs idle; u_inv has its active-low src1 held inactive (1)
    sys_rst_n = 1'b0;
    req_in    = 3'b000;
    ack       = 1'b0;
    clr_all   = 1'b0;
    req_inv   = 3'b010;
    ack_inv   = 1'b0;
    clr_inv   = 1'b0;
    #2;
    push_exp(pack(3'b000, 0, 2'b00, S_IDLE));
    pop_cmp("reset_main", obs_main);
    push_exp(pack(3'b000, 0, 2'b00, S_IDLE));
    pop_cmp("reset_inv", obs_inv);
    repeat (2) @(posedge sysclk);
    #1;
    sys_rst_n = 1'b1;

    // table-driven main sequences
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].req, tbl[k].ack, tbl[k].clr,
           pack(tbl[k].pend, tbl[k].irq, tbl[k].lvl, tbl[k].st),
           $sformatf("vec[%0d]", k));
    end

    // inverted source: held high since reset produced nothing
    push_exp(pack(3'b000, 0, 2'b00, S_IDLE));
    pop_cmp("inv_idle_held", obs_inv);
    // driving it low is the active edge
    step_inv(3'b000, 0, pack(3'b000, 0, 2'b00, S_IDLE), "inv_e1");
    step_inv(3'b000, 0, pack(3'b000, 0, 2'b00, S_IDLE), "inv_e2");
    step_inv(3'b000, 0, pack(3'b010, 0, 2'b00, S_IDLE), "inv_e3");
    step_inv(3'b000, 0, pack(3'b010, 1, 2'b10, S_REQ),  "inv_e4");
    step_inv(3'b000, 1, pack(3'b000, 0, 2'b00, S_WAIT), "inv_ack");
    step_inv(3'b000, 0, pack(3'b000, 0, 2'b00, S_IDLE), "inv_ack_low");
    for (int k = 0; k < 4; k++) begin
      step_inv(3'b000, 0, pack(3'b000, 0, 2'b00, S_IDLE), $sformatf("inv_hold[%0d]", k));
    end

    // asynchronous reset mid-REQ, with src0 held high through reset release
    step(3'b001, 0, 0, pack(3'b000, 0, 2'b00, S_IDLE), "ar_e1");
    step(3'b001, 0, 0, pack(3'b000, 0, 2'b00, S_IDLE), "ar_e2");
    step(3'b001, 0, 0, pack(3'b001, 0, 2'b00, S_IDLE), "ar_e3");
    step(3'b001, 0, 0, pack(3'b001, 1, 2'b01, S_REQ),  "ar_req");
    step(3'b001, 0, 0, pack(3'b001, 1, 2'b01, S_REQ),  "ar_held");
    #3;
    sys_rst_n = 1'b0;
    #1;
    push_exp(pack(3'b000, 0, 2'b00, S_IDLE));
    pop_cmp("ar_async", obs_main);
    @(posedge sysclk);
    #1;
    push_exp(pack(3'b000, 0, 2'b00, S_IDLE));
    pop_cmp("ar_in_reset", obs_main);
    sys_rst_n = 1'b1;
    step(3'b001, 0, 0, pack(3'b000, 0, 2'b00, S_IDLE), "rel_e1");
    step(3'b001, 0, 0, pack(3'b000, 0, 2'b00, S_IDLE), "rel_e2");
    step(3'b001, 0, 0, pack(3'b001, 0, 2'b00, S_IDLE), "rel_e3");
    step(3'b001, 0, 0, pack(3'b001, 1, 2'b01, S_REQ),  "rel_e4");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
